dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the RISC-V core; the memory stage issues load/store requests and this block services them.
- Holds a word-organised on-chip RAM with byte-enable writes and address-range and alignment checking.
- Returns one response per accepted request over a valid/ready channel.
- Sits between the memory stage and the FPGA block RAM.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM; power of two, at least 16.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.
- MMIO_ADDR, 32'hFFFF_FFF0, byte address of the MMIO register; used only when DMEM_MMIO_EN is defined.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, little-endian lanes.
- req_be  in  4  store byte enables; ignored for loads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  request was misaligned or out of range.
- mmio_out  out  32  MMIO register value; tied 0 when DMEM_MMIO_EN is undefined.

Behaviour:
- Reset: synchronous, active-low. On a clk edge with rst_n=0:
  - state <= IDLE
  - rsp_valid <= 0, rsp_rdata <= 0, rsp_err <= 0
  - mmio register <= 0
  - RAM contents are not reset.
  - Any in-flight request or pending response is dropped silently.
- Handshake: a transfer occurs on any cycle where valid and ready are both 1. Requester inputs are sampled only on the accept cycle. rsp_* outputs hold stable while rsp_valid=1 and rsp_ready=0.
- States:
  - IDLE: req_ready=1. On accept go to BUSY.
  - BUSY: req_ready=0. RAM read completes; the response is registered. Go to RESP.
  - RESP: rsp_valid=1; req_ready = rsp_ready.
    - rsp_ready=1 and req_valid=1: accept the new request, go to BUSY (back-to-back).
    - rsp_ready=1 and req_valid=0: go to IDLE.
    - rsp_ready=0: stay in RESP.
- Latency and throughput: a request accepted in cycle C has rsp_valid=1 in cycle C+2, for loads and stores alike. Sustained throughput is one transaction per 2 cycles.
- Decode:
  - idx = (req_addr - BASE_ADDR) >> 2.
  - in_range = (req_addr - BASE_ADDR) < DEPTH_WORDS*4, compared as unsigned 32-bit; wrap-around below BASE_ADDR counts as out of range.
  - misaligned = req_addr[1:0] != 0.
  - err = misaligned | !in_range.
- Store:
  - Performed on the accept edge. Only lanes with req_be[i]=1 are written, byte i = wdata[8i+7:8i].
  - req_be=4'b0000 is legal: no write, normal response.
  - On err, no write.
  - Response: rdata=0, err as decoded.
- Load:
  - Returns the full 32-bit word at idx; sub-word extraction is the requester's job.
  - On err, rdata=0 and err=1.
- Ordering: a store followed by a load to the same word returns the post-store data, including the back-to-back case. No reordering occurs.
- Reset mid-operation: after rst_n returns to 1, the block is in IDLE with req_ready=1 on the next cycle.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- Defined:
  - An access with req_addr == MMIO_ADDR targets a 32-bit register instead of the RAM, with no error.
  - Stores update the register per req_be, on the accept edge.
  - Loads return the register value.
  - mmio_out continuously drives the register.
  - Timing and handshake are identical to RAM accesses.
- Undefined:
  - MMIO_ADDR is decoded like any other address (normally out of range, so err=1).
  - mmio_out = 0 constantly.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mmio_out=0.
- Store then load: store 0xDEADBEEF to 0x10 with be=4'hF, then load 0x10 -> both responses arrive 2 cycles after accept; load rdata=0xDEADBEEF, err=0.
- Byte-enable store: word 0x20=0x11223344, store 0xAABBCCDD with be=4'b0101, then load 0x20 -> rdata=0x11BB33DD.
- Errors: load 0x22 -> err=1, rdata=0. Store to BASE_ADDR+DEPTH_WORDS*4 -> err=1, and a following load of word DEPTH_WORDS-1 is unchanged.
- Backpressure and back-to-back:
  - Hold rsp_ready=0 for 5 cycles during a load response -> rsp_valid and rsp_rdata stay stable and req_ready=0.
  - Then set rsp_ready=1 with a store pending on req_valid -> the store is accepted in the same cycle and its response arrives 2 cycles later.
- MMIO (with DMEM_MMIO_EN): store 0x000000A5 to 0xFFFFFFF0 -> mmio_out=0x000000A5 on the cycle after accept, and a load of 0xFFFFFFF0 returns 0xA5 with err=0. Without the macro the same store returns err=1 and mmio_out stays 0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM behind a valid/ready request/response pair.
// Latency: response valid two cycles after the accept edge; one transaction per two cycles sustained.
// Backpressure: rsp_* hold while rsp_ready=0; req_ready drops until the pending response is taken.
//
// Ports: clk/rst_n (sync active-low), req_valid/req_ready/req_we/req_addr/req_wdata/req_be,
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err, mmio_out.
// Optional: define DMEM_MMIO_EN to map a 32-bit register at MMIO_ADDR (driven on mmio_out).
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mmio_out
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

`ifdef DMEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic        mmio_sel_q, mmio_sel_d;
  logic [31:0] mmio_q, mmio_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] ram_rdata_q;

  logic [31:0] offset;
  logic [AW-1:0] idx;
  logic        in_range, misaligned, mmio_hit, err, accept;

  // Subtracting first makes addresses below BASE_ADDR wrap to huge offsets,
  // so a single unsigned compare covers both range ends.
  assign offset     = req_addr - BASE_ADDR;
  assign idx        = offset[AW+1:2];
  assign in_range   = offset < SPAN;
  assign misaligned = req_addr[1:0] != 2'b00;
  assign mmio_hit   = MMIO_EN && (req_addr == MMIO_ADDR);
  assign err        = !mmio_hit && (misaligned || !in_range);

  assign req_ready  = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign accept     = req_valid && req_ready;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign mmio_out   = MMIO_EN ? mmio_q : 32'h0;

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    we_d        = we_q;
    mmio_sel_d  = mmio_sel_q;
    mmio_d      = mmio_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    if (accept) begin
      err_d      = err;
      we_d       = req_we;
      mmio_sel_d = mmio_hit;
      if (req_we && mmio_hit) begin
        for (int i = 0; i < 4; i++) begin
          if (req_be[i]) mmio_d[8*i +: 8] = req_wdata[8*i +: 8];
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (accept) state_d = BUSY;
      end
      BUSY: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        // Stores and errored accesses return zero data.
        if (err_q || we_q) rsp_rdata_d = 32'h0;
        else               rsp_rdata_d = mmio_sel_q ? mmio_q : ram_rdata_q;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = accept ? BUSY : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      mmio_sel_q  <= 1'b0;
      mmio_q      <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      we_q        <= we_d;
      mmio_sel_q  <= mmio_sel_d;
      mmio_q      <= mmio_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Block-RAM style port: write and synchronous read share the accept edge.
  // A request is either a load or a store, so there is no read/write collision;
  // a later load always sees earlier stores.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      if (req_we && !err && !mmio_hit) begin
        for (int i = 0; i < 4; i++) begin
          if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
      ram_rdata_q <= mem[idx];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, backpressure and
// reset corner sequences, then randomized traffic against an address-map model.
module tb_dmem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] MMIO  = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_be = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mmio_out;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .MMIO_ADDR(MMIO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mmio_out(mmio_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] mem_m [int];
  logic [31:0] mmio_m = 32'h0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
`ifdef DMEM_MMIO_EN
    return a == MMIO;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic model_err(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (is_mmio(a)) return 1'b0;
    return (a[1:0] != 2'b00) || (off >= DEPTH * 4);
  endfunction

  // One complete transaction with rsp_ready held high. Returns data, error flag,
  // accept-to-response latency in cycles and mmio_out one cycle after accept.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output logic [31:0] rdata, output logic err,
                      output int lat, output logic [31:0] mmio_after);
    int waits;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    waits = 0;
    while (!req_ready && waits < 20) begin @(negedge clk); waits++; end
    if (!req_ready) check("req_ready timeout", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    mmio_after = mmio_out;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    rdata = rsp_rdata;
    err   = rsp_err;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, mm, a, wd, exp_rd, prev;
    logic        er, we, exp_er;
    logic [3:0]  be;
    int          lat;
    int          pool[10];

    // Reset then idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset req_ready", {31'h0, req_ready}, 32'h1);
    check("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset rsp_err",   {31'h0, rsp_err}, 32'h0);
    check("reset mmio_out",  mmio_out, 32'h0);

    // Directed vector table
    vecs.push_back('{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h20,   32'h11223344, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0});
    vecs.push_back('{1'b0, 32'h22,   32'h0,        4'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'hFFC,  32'h5A5A5A5A, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'hFFC,  32'h0,        4'h0, 32'h5A5A5A5A, 1'b0});
    vecs.push_back('{1'b1, 32'h10,   32'h12345678, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h21,   32'h99999999, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0});
`ifdef DMEM_MMIO_EN
    vecs.push_back('{1'b1, MMIO,     32'h000000A5, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, MMIO,     32'h0,        4'h0, 32'h000000A5, 1'b0});
`else
    vecs.push_back('{1'b1, MMIO,     32'h000000A5, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{1'b0, MMIO,     32'h0,        4'h0, 32'h0, 1'b1});
`endif

    foreach (vecs[i]) begin
      xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat, mm);
      if (vecs[i].we && is_mmio(vecs[i].addr)) mmio_m = merge(mmio_m, vecs[i].wdata, vecs[i].be);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
      check($sformatf("vec%0d mmio_out", i), mm, mmio_m);
    end

    // Backpressure on a load response, with a store waiting on the request side
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp busy rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    check("bp rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("bp rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h0BADF00D; req_be = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp hold%0d rsp_valid", k), {31'h0, rsp_valid}, 32'h1);
      check($sformatf("bp hold%0d rsp_rdata", k), rsp_rdata, 32'hDEADBEEF);
      check($sformatf("bp hold%0d req_ready", k), {31'h0, req_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp release req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp store busy", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    check("bp store rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("bp store rsp_err", {31'h0, rsp_err}, 32'h0);
    check("bp store rsp_rdata", rsp_rdata, 32'h0);
    // Back-to-back load of the word just stored
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h30; req_be = 4'h0;
    #1;
    check("b2b req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b busy", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    check("b2b rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("b2b rsp_rdata", rsp_rdata, 32'h0BADF00D);

    // Randomized traffic against the model
    for (int k = 0; k < 8; k++) pool[k] = k;
    pool[8] = 100;
    pool[9] = DEPTH - 1;
    foreach (pool[k]) begin
      wd = $urandom;
      a  = BASE + 32'(pool[k]) * 4;
      xact(1'b1, a, wd, 4'hF, rd, er, lat, mm);
      mem_m[pool[k]] = wd;
      check($sformatf("init%0d err", k), {31'h0, er}, 32'h0);
    end
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE + 32'(pool[$urandom_range(0, 9)]) * 4 + 32'($urandom_range(1, 3));
        1:       a = 32'h8000_0000 | $urandom;
        2:       a = MMIO;
        3:       a = BASE + 32'(DEPTH * 4);
        default: a = BASE + 32'(pool[$urandom_range(0, 9)]) * 4;
      endcase
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      be = 4'($urandom);
      exp_er = model_err(a);
      exp_rd = 32'h0;
      if (!we && !exp_er) exp_rd = is_mmio(a) ? mmio_m : mem_m[int'((a - BASE) >> 2)];
      xact(we, a, wd, be, rd, er, lat, mm);
      if (we && !exp_er) begin
        if (is_mmio(a)) mmio_m = merge(mmio_m, wd, be);
        else            mem_m[int'((a - BASE) >> 2)] = merge(mem_m[int'((a - BASE) >> 2)], wd, be);
      end
      check($sformatf("rand%0d addr=%08h we=%0d rdata", k, a, we), rd, exp_rd);
      check($sformatf("rand%0d addr=%08h err", k, a), {31'h0, er}, {31'h0, exp_er});
      check($sformatf("rand%0d latency", k), 32'(lat), 32'd2);
      check($sformatf("rand%0d mmio_out", k), mm, mmio_m);
    end

    // Reset while a load is in flight: response dropped, block idle right after
    prev = mem_m[0];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = BASE; req_be = 4'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst req_ready", {31'h0, req_ready}, 32'h1);
    check("midrst rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("midrst rsp_rdata", rsp_rdata, 32'h0);
    check("midrst mmio_out",  mmio_out, 32'h0);
    mmio_m = 32'h0;
    @(negedge clk);
    check("midrst dropped", {31'h0, rsp_valid}, 32'h0);
    xact(1'b0, BASE, 32'h0, 4'h0, rd, er, lat, mm);
    check("post-reset load rdata", rd, prev);
    check("post-reset load latency", 32'(lat), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
